// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver producing the 11-bit ps2_key event word
module ps2_key_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bitcnt_q;
  logic [8:0]    shift_q;
  logic [TW-1:0] tcnt_q;
  logic          ext_q, brk_q;
  logic [2:0]    skip_q;
  logic [10:0]   key_q;
  logic          err_q;

  logic       sample, dat, frame_ok, is_resp;
  logic [7:0] byte_w;

  // Filtered clock flips only after FILTER_LEN consecutive cycles at the opposite level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign sample   = filt_q & ~filt_d;
  assign dat      = dat_sync_q[1];
  assign byte_w   = shift_q[7:0];
  assign frame_ok = (^shift_q) & dat;
  assign is_resp  = (byte_w == 8'hAA) || (byte_w == 8'hFA) || (byte_w == 8'hFE) ||
                    (byte_w == 8'hEE) || (byte_w == 8'h00) || (byte_w == 8'hFF);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      tcnt_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      key_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      err_q      <= 1'b0;
      if (sample) begin
        tcnt_q <= '0;
        if (bitcnt_q == 4'd0) begin
          if (!dat) bitcnt_q <= 4'd1;
        end else if (bitcnt_q != 4'd10) begin
          shift_q  <= {dat, shift_q[8:1]};
          bitcnt_q <= bitcnt_q + 4'd1;
        end else begin
          bitcnt_q <= 4'd0;
          if (!frame_ok) begin
            err_q  <= 1'b1;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
          end else if (skip_q != 3'd0) begin
            skip_q <= skip_q - 3'd1;
          end else if (byte_w == 8'hE1) begin
            skip_q <= 3'd7;
          end else if (byte_w == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (byte_w == 8'hF0) begin
            brk_q <= 1'b1;
          end else if (!(is_resp && !ext_q && !brk_q)) begin
            key_q <= {~key_q[10], ~brk_q, ext_q, byte_w};
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end
        end
      end else if (bitcnt_q == 4'd0) begin
        tcnt_q <= '0;
      end else if (tcnt_q == TW'(TIMEOUT)) begin
        // Abandon the partial frame; prefix flags survive.
        bitcnt_q <= 4'd0;
        err_q    <= 1'b1;
        tcnt_q   <= '0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - scoreboard bench for ps2_key_rx with a byte-level reference model
module tb_ps2_key_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1500;
  localparam int HALF       = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          is_err;
    logic [10:0] key;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bit m_tog = 1'b0, m_ext = 1'b0, m_brk = 1'b0;
  int m_skip = 0;

  function automatic bit is_resp(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF;
  endfunction

  function automatic void push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.key    = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    exp_t e;
    if (!ok) begin
      push_err();
      m_ext = 0; m_brk = 0; m_skip = 0;
    end else if (m_skip != 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!(is_resp(b) && !m_ext && !m_brk)) begin
      m_tog    = ~m_tog;
      e.is_err = 1'b0;
      e.key    = {m_tog, ~m_brk, m_ext, b};
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  task automatic ps2_bit(input logic d, input bit glitch);
    ps2_data = d;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b1;
    if (glitch) begin
      repeat (5) @(posedge clk_sys);
      ps2_clk = 1'b0;
      repeat (3) @(posedge clk_sys);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_bit);
    logic [10:0] bits;
    model_byte(b, !bad_par && !bad_stop);
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == glitch_bit);
    ps2_data = 1'b1;
    repeat (3 * HALF) @(posedge clk_sys);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_frame(bs[i], 1'b0, 1'b0, -1);
  endtask

  task automatic send_timeout(input int pulses);
    push_err();
    for (int i = 0; i < pulses; i++) ps2_bit(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 100) @(posedge clk_sys);
  endtask

  // Stimulus
  initial begin
    logic [7:0] b;
    int r;
    repeat (5) @(posedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(posedge clk_sys);
    send_bytes('{8'h1C});
    send_bytes('{8'hF0, 8'h75});
    send_bytes('{8'hE0, 8'hF0, 8'h74, 8'hE0, 8'h74});
    send_bytes('{8'hE0});
    send_frame(8'h29, 1'b1, 1'b0, -1);
    send_bytes('{8'h29});
    send_frame(8'h33, 1'b0, 1'b1, -1);
    send_bytes('{8'hAA, 8'hFA, 8'hF0, 8'hAA});
    send_timeout(5);
    send_bytes('{8'h16});
    send_bytes('{8'hE0});
    send_timeout(7);
    send_bytes('{8'h16});
    send_bytes('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    send_frame(8'h5A, 1'b0, 1'b0, 4);
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hE1;
        5:       b = 8'hAA;
        6:       b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 15);
      send_frame(b, r == 0, r == 1, (r == 2) ? int'($urandom_range(1, 9)) : -1);
    end
    repeat (200) @(posedge clk_sys);
    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    exp_t        e;
    logic [10:0] prev_key;
    int          cyc = 0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if (ps2_key !== 11'h000) begin
      errors++;
      $display("FAIL reset_key: got %h expected %h", ps2_key, 11'h000);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", frame_err);
    end
    prev_key = 11'h000;
    while (!stim_done && cyc < 90000) begin
      @(negedge clk_sys);
      cyc++;
      if (frame_err === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err: got frame_err=1 expected no event");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_err) begin
            errors++;
            $display("FAIL event_kind: got frame_err expected ps2_key=%h", e.key);
          end
        end
      end
      if (ps2_key !== prev_key) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key: got %h expected no change from %h", ps2_key, prev_key);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err || ps2_key !== e.key) begin
            errors++;
            $display("FAIL key_event: got %h expected %s %h", ps2_key,
                     e.is_err ? "frame_err" : "key", e.key);
          end
        end
        prev_key = ps2_key;
      end
    end
    checks++;
    if (!stim_done) begin
      errors++;
      $display("FAIL cycle_budget: got %0d cycles without completion expected under 90000", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
